// File: rtl/popsel_iter_if.sv
// popsel_iter_if: request/result bundle for the iterative bit-select unit.
// The requester drives Start/Flush/A/N; the unit returns Busy/Done/Found/Index/Mask.
interface popsel_iter_if #(
    parameter int WIDTH = 64
);
    localparam int IW = $clog2(WIDTH);

    logic             Start;
    logic             Flush;
    logic [WIDTH-1:0] A;
    logic [IW-1:0]    N;
    logic             Busy;
    logic             Done;
    logic             Found;
    logic [IW-1:0]    Index;
    logic [WIDTH-1:0] Mask;

    modport master (
        output Start, Flush, A, N,
        input  Busy, Done, Found, Index, Mask
    );

    modport slave (
        input  Start, Flush, A, N,
        output Busy, Done, Found, Index, Mask
    );
endinterface

// File: rtl/popsel_iter.sv
// popsel_iter: iterative select (inverse of popcount). Returns the bit index and
// one-hot mask of the N-th set bit of A, scanning one CHUNK per cycle.
// Optional macro POPSEL_EARLYOUT_EN: a full-width popcount in the first SCAN
// cycle lets a miss finish immediately instead of scanning every chunk.
module popsel_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         reset,
    popsel_iter_if.slave bus
);
    localparam int IW  = $clog2(WIDTH);
    localparam int CW  = $clog2(CHUNK) + 1;
    localparam int NCH = WIDTH / CHUNK;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op;
    logic [IW-1:0]    r_rem;
    logic [PW-1:0]    r_ptr;
    logic             r_found;
    logic [IW-1:0]    r_index;
    logic [WIDTH-1:0] r_mask;

    logic [CHUNK-1:0] w_chunk;
    logic [CW-1:0]    w_cnt;
    logic [OW-1:0]    w_off;
    logic             w_hit;
    logic             w_last;
    logic             w_early;
    logic             w_accept;
    logic [IW-1:0]    w_hit_index;
    logic [WIDTH-1:0] w_hit_mask;

    function automatic logic [CW-1:0] pop_chunk(input logic [CHUNK-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < CHUNK; i++) s = s + CW'(v[i]);
        return s;
    endfunction

    assign w_chunk  = r_op[int'(r_ptr)*CHUNK +: CHUNK];
    assign w_cnt    = pop_chunk(w_chunk);
    assign w_hit    = ({1'b0, r_rem} < (IW+1)'(w_cnt));
    assign w_last   = (r_ptr == PW'(NCH-1));
    assign w_accept = bus.Start && !bus.Flush;

`ifdef POPSEL_EARLYOUT_EN
    logic [IW:0] w_total;

    // Full-width popcount of the latched operand, used only in the first SCAN cycle
    always_comb begin
        w_total = '0;
        for (int unsigned i = 0; i < WIDTH; i++) w_total = w_total + (IW+1)'(r_op[i]);
    end

    // r_ptr is zero only during the first SCAN cycle, when r_rem still equals N
    assign w_early = (r_ptr == '0) && ({1'b0, r_rem} >= w_total);
`else
    assign w_early = 1'b0;
`endif

    // Locate the r_rem-th set bit inside the current chunk
    always_comb begin
        logic [CW-1:0] v_run;
        v_run = '0;
        w_off = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (w_chunk[i] && ((IW+1)'(v_run) == {1'b0, r_rem})) w_off = OW'(i);
            v_run = v_run + CW'(w_chunk[i]);
        end
    end

    assign w_hit_index = IW'(int'(r_ptr)*CHUNK + int'(w_off));
    assign w_hit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << w_hit_index;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; Flush wins over everything while an operation is active
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_SCAN;
            S_SCAN: begin
                if (bus.Flush)                          w_next = S_IDLE;
                else if (w_hit || w_last || w_early)    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs; a Flush coincident with DONE suppresses the pulse
    always_comb begin
        bus.Busy = (r_state != S_IDLE);
        bus.Done = (r_state == S_DONE) && !bus.Flush;
    end

    // Operand latch, scan bookkeeping and held result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= '0;
            r_rem   <= '0;
            r_ptr   <= '0;
            r_found <= 1'b0;
            r_index <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.A;
                        r_rem   <= bus.N;
                        r_ptr   <= '0;
                        r_found <= 1'b0;
                        r_index <= '0;
                        r_mask  <= '0;
                    end
                end
                S_SCAN: begin
                    if (bus.Flush) begin
                        r_found <= 1'b0;
                        r_index <= '0;
                        r_mask  <= '0;
                    end else if (w_hit) begin
                        r_found <= 1'b1;
                        r_index <= w_hit_index;
                        r_mask  <= w_hit_mask;
                    end else begin
                        // Only reached when r_rem >= w_cnt, so no underflow
                        r_rem <= r_rem - IW'(w_cnt);
                        if (w_last || w_early) begin
                            r_found <= 1'b0;
                            r_index <= '0;
                            r_mask  <= '0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.Flush) begin
                        r_found <= 1'b0;
                        r_index <= '0;
                        r_mask  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Found = r_found;
    assign bus.Index = r_index;
    assign bus.Mask  = r_mask;
endmodule

// File: tb/tb_popsel_iter.sv
// tb_popsel_iter: directed vector table plus hand-written corner sequences
// for popsel_iter (WIDTH=64, CHUNK=8).
module tb_popsel_iter;
    localparam int WIDTH = 64;
    localparam int CHUNK = 8;
`ifdef POPSEL_EARLYOUT_EN
    localparam int MISS_LAT = 1;
`else
    localparam int MISS_LAT = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    popsel_iter_if #(.WIDTH(WIDTH)) bus ();

    popsel_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] a;
        logic [5:0]  n;
        logic        found;
        logic [5:0]  idx;
        logic [63:0] mask;
        int          lat;   // edges after the Start edge until Done is seen
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count edges until Done is observed; -1 if it never arrives within the budget
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.Done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [5:0] n, output int lat);
        bus.A = a; bus.N = n; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.A = ~a;
        bus.N = ~n;
        check({tag, " busy"}, 64'(bus.Busy), 64'd1);
        check({tag, " cleared"}, {63'd0, bus.Found} | bus.Mask, 64'd0);
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{64'h1,                     6'd0,  1'b1, 6'd0,  64'h1,                     1};
        vecs[1]  = '{64'h8000_0000_0000_0000,   6'd0,  1'b1, 6'd63, 64'h8000_0000_0000_0000,   8};
        vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF,   6'd37, 1'b1, 6'd37, 64'h0000_0020_0000_0000,   5};
        vecs[3]  = '{64'hF0F0,                  6'd5,  1'b1, 6'd13, 64'h2000,                  2};
        vecs[4]  = '{64'h0F,                    6'd4,  1'b0, 6'd0,  64'h0,                     MISS_LAT};
        vecs[5]  = '{64'h6,                     6'd1,  1'b1, 6'd2,  64'h4,                     1};
        vecs[6]  = '{64'h0,                     6'd0,  1'b0, 6'd0,  64'h0,                     MISS_LAT};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF,   6'd63, 1'b1, 6'd63, 64'h8000_0000_0000_0000,   8};
        vecs[8]  = '{64'h0000_0100_0000_0000,   6'd0,  1'b1, 6'd40, 64'h0000_0100_0000_0000,   6};
        vecs[9]  = '{64'h8000_0000_0000_0001,   6'd1,  1'b1, 6'd63, 64'h8000_0000_0000_0000,   8};
        vecs[10] = '{64'h8000_0000_0000_0001,   6'd2,  1'b0, 6'd0,  64'h0,                     MISS_LAT};
        vecs[11] = '{64'h0000_0000_0300_0000,   6'd1,  1'b1, 6'd25, 64'h0000_0000_0200_0000,   4};
        vecs[12] = '{64'hFF00_0000_0000_00FF,   6'd9,  1'b1, 6'd57, 64'h0200_0000_0000_0000,   8};

        bus.Start = 1'b0; bus.Flush = 1'b0; bus.A = '0; bus.N = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy",  64'(bus.Busy),  64'd0);
        check("rst done",  64'(bus.Done),  64'd0);
        check("rst found", 64'(bus.Found), 64'd0);
        check("rst index", 64'(bus.Index), 64'd0);
        check("rst mask",  bus.Mask,       64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].n, lat);
            check($sformatf("v%0d lat", i),   64'(lat),          64'(vecs[i].lat));
            check($sformatf("v%0d found", i), 64'(bus.Found),    64'(vecs[i].found));
            check($sformatf("v%0d index", i), 64'(bus.Index),    64'(vecs[i].idx));
            check($sformatf("v%0d mask", i),  bus.Mask,          vecs[i].mask);
            @(posedge clk); #1;
            check($sformatf("v%0d pulse", i), {62'd0, bus.Done, bus.Busy}, 64'd0);
            check($sformatf("v%0d hold", i),  bus.Mask,          vecs[i].mask);
        end

        // Second Start one cycle after the first is ignored
        bus.A = 64'h1; bus.N = 6'd0; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.A = 64'h100; bus.N = 6'd0;
        wait_done(lat);
        bus.Start = 1'b0;
        check("restart1 lat",   64'(lat),       64'd1);
        check("restart1 index", 64'(bus.Index), 64'd0);
        check("restart1 mask",  bus.Mask,       64'h1);
        @(posedge clk); #1;
        check("restart1 idle",  64'(bus.Busy),  64'd0);

        // Start held through a long scan with a different operand
        bus.A = 64'h8000_0000_0000_0000; bus.N = 6'd0; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.A = 64'h1;
        wait_done(lat);
        bus.Start = 1'b0;
        check("restart2 lat",   64'(lat),       64'd8);
        check("restart2 index", 64'(bus.Index), 64'd63);
        @(posedge clk); #1;
        check("restart2 idle",  64'(bus.Busy),  64'd0);

        // Flush of an all-zero scan: sampled at edge t+3, no Done afterwards
        bus.A = 64'h0; bus.N = 6'd0; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flush pre busy", 64'(bus.Busy), 64'd1);
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        check("flush busy", 64'(bus.Busy), 64'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.Done || bus.Busy) seen++;
            @(posedge clk); #1;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush outs", {63'd0, bus.Found} | bus.Mask | 64'(bus.Index), 64'd0);

        // Flush coincident with the DONE cycle suppresses Done and clears the result
        bus.A = 64'h1; bus.N = 6'd0; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(posedge clk); #1;
        check("fdone found", 64'(bus.Found), 64'd1);
        bus.Flush = 1'b1;
        #1;
        check("fdone done", 64'(bus.Done), 64'd0);
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        check("fdone busy",  64'(bus.Busy),  64'd0);
        check("fdone found0", 64'(bus.Found), 64'd0);
        check("fdone mask0", bus.Mask, 64'd0);

        // Start with Flush in IDLE is not accepted; held result stays
        run_op("pre", 64'h6, 6'd1, lat);
        @(posedge clk); #1;
        bus.A = 64'h1; bus.N = 6'd0; bus.Start = 1'b1; bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.Flush = 1'b0;
        check("sflush busy",  64'(bus.Busy),  64'd0);
        check("sflush index", 64'(bus.Index), 64'd2);
        @(posedge clk); #1;
        check("sflush idle",  64'(bus.Busy),  64'd0);

        // Asynchronous reset mid-SCAN
        bus.A = 64'h0; bus.N = 6'd0; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst busy", 64'(bus.Busy), 64'd0);
        check("arst done", 64'(bus.Done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Asynchronous reset while a result is held
        run_op("held", 64'hF0F0, 6'd5, lat);
        @(posedge clk); #2;
        check("held index", 64'(bus.Index), 64'd13);
        reset = 1'b1;
        #1;
        check("arst outs", {63'd0, bus.Found} | bus.Mask | 64'(bus.Index), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("post", 64'h6, 6'd1, lat);
        check("post lat",   64'(lat),       64'd1);
        check("post index", 64'(bus.Index), 64'd2);
        check("post mask",  bus.Mask,       64'h4);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
